wb_unified_mem_arbiter: RTL and testbench

Two-master to one-slave Wishbone arbiter that shares a single-port unified memory between the core's instruction-fetch bus (iwb) and data bus (dwb).
- Sits between `custom_riscv_core` and the unified code/data RAM, so self-modifying code and FENCE.I see one coherent memory.
- Grants one transfer at a time with round-robin fairness.
- Rejects out-of-range addresses and guards against a hung slave with a watchdog that returns an error.

---
 rtl/wb_unified_mem_arbiter_pkg.sv | 30 +++
 rtl/wb_arb_watchdog.sv | 32 +++
 rtl/wb_unified_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_unified_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory Wishbone arbiter: FSM states,
// grant identifiers and the master-selection rule.
package wb_unified_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT_I = 3'd1,
    ST_GRANT_D = 3'd2,
    ST_ERR     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int WD_WIDTH = 16;

  // On a tie the master that did not win last time is chosen.
  function automatic logic pick_master(input logic req_i, input logic req_d,
                                       input logic last_grant);
    if (req_i && req_d) begin
      return (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_i) begin
      return GNT_I;
    end else begin
      return GNT_D;
    end
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating cycle counter that flags a granted transfer which has waited
// TIMEOUT_CYCLES-1 cycles without a slave response.
module wb_arb_watchdog
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WD_WIDTH-1:0] LIMIT   = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_WIDTH-1:0] SAT_MAX = {WD_WIDTH{1'b1}};

  logic [WD_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != SAT_MAX)) begin
      count <= count + WD_WIDTH'(1);
    end
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port code/data memory between the
// instruction-fetch and data Wishbone masters, with range check and watchdog.
module wb_unified_mem_arbiter
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_8000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  state_t      state;
  state_t      next_state;
  logic        last_grant;
  logic        owner;
  logic        req_i;
  logic        req_d;
  logic        any_req;
  logic        sel_m;
  logic [31:0] sel_adr;
  logic        sel_oor;
  logic        owner_cyc;
  logic        in_grant;
  logic        wd_expired;

  assign req_i     = iwb_cyc_i && iwb_stb_i;
  assign req_d     = dwb_cyc_i && dwb_stb_i;
  assign any_req   = req_i || req_d;
  assign sel_m     = pick_master(req_i, req_d, last_grant);
  assign sel_adr   = (sel_m == GNT_I) ? iwb_adr_i : dwb_adr_i;
  assign sel_oor   = (sel_adr >= ADDR_LIMIT);
  assign in_grant  = (state == ST_GRANT_I) || (state == ST_GRANT_D);
  assign owner_cyc = (state == ST_GRANT_I) ? iwb_cyc_i : dwb_cyc_i;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_IDLE),
    .en     (in_grant),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Reset to D so the very first tie after reset goes to the fetch bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_D;
      owner      <= GNT_I;
    end else if ((state == ST_IDLE) && any_req) begin
      last_grant <= sel_m;
      owner      <= sel_m;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!any_req) begin
          next_state = ST_IDLE;
        end else if (sel_oor) begin
          next_state = ST_ERR;
        end else if (sel_m == GNT_I) begin
          next_state = ST_GRANT_I;
        end else begin
          next_state = ST_GRANT_D;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        // A slave response in the final watchdog cycle beats the timeout.
        if (m_ack_i || m_err_i) begin
          next_state = ST_DONE;
        end else if (!owner_cyc) begin
          next_state = ST_IDLE;
        end else if (wd_expired) begin
          next_state = ST_ERR;
        end else begin
          next_state = state;
        end
      end
      ST_ERR:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    m_adr_o   = 32'h0000_0000;
    m_dat_o   = 32'h0000_0000;
    m_we_o    = 1'b0;
    m_sel_o   = 4'h0;
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    iwb_dat_o = 32'h0000_0000;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    dwb_dat_o = 32'h0000_0000;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    case (state)
      ST_GRANT_I: begin
        m_adr_o   = iwb_adr_i;
        m_sel_o   = 4'hF;
        m_cyc_o   = iwb_cyc_i;
        m_stb_o   = iwb_stb_i;
        iwb_dat_o = m_dat_i;
        iwb_ack_o = m_ack_i && !m_err_i;
        iwb_err_o = m_err_i;
      end
      ST_GRANT_D: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_we_o    = dwb_we_i;
        m_sel_o   = dwb_sel_i;
        m_cyc_o   = dwb_cyc_i;
        m_stb_o   = dwb_stb_i;
        dwb_dat_o = m_dat_i;
        dwb_ack_o = m_ack_i && !m_err_i;
        dwb_err_o = m_err_i;
      end
      ST_ERR: begin
        if (owner == GNT_I) begin
          iwb_err_o = 1'b1;
        end else begin
          dwb_err_o = 1'b1;
        end
      end
      default: begin
        m_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Scoreboard bench for wb_unified_mem_arbiter: queued master transactions,
// a registered-ack slave model and in-order response checking.
module tb_wb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iwb_adr_i, iwb_dat_o, dwb_adr_i, dwb_dat_i, dwb_dat_o;
  logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
  logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
  logic [3:0]  dwb_sel_i, m_sel_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;

  typedef struct {logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel;} tx_t;
  typedef struct {logic who; logic [1:0] resp; logic [31:0] data; int cyc;} exp_t;

  tx_t  i_q[$];
  tx_t  d_q[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  int   slave_mode = 0;
  logic stb_seen = 1'b0;
  logic last_err_stb = 1'b0;

  wb_unified_mem_arbiter #(
    .ADDR_LIMIT(32'h0000_8000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
    .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    else return {a[15:0], 16'hBEEF};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Slave: registered response one cycle after it sees a strobe.
  logic        s_ack, s_err;
  logic [31:0] s_dat;
  assign m_ack_i = s_ack;
  assign m_err_i = s_err;
  assign m_dat_i = s_dat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_dat <= 32'h0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_dat <= rdata_fn(m_adr_o);
      if (m_cyc_o && m_stb_o && !s_ack && !s_err) begin
        if (slave_mode == 0) s_ack <= 1'b1;
        else if (slave_mode == 2) begin
          s_ack <= 1'b1;
          s_err <= 1'b1;
        end
      end
    end
  end

  task automatic resp(input logic who);
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    tx_t t;
    ack = who ? dwb_ack_o : iwb_ack_o;
    err = who ? dwb_err_o : iwb_err_o;
    dat = who ? dwb_dat_o : iwb_dat_o;
    check_eq("other_quiet", who ? (iwb_ack_o | iwb_err_o) : (dwb_ack_o | dwb_err_o), 64'd0);
    if (sb.size() == 0) begin
      check_eq("unexpected_resp", {63'd0, who}, 64'd2);
    end else begin
      e = sb.pop_front();
      check_eq("resp_master", {63'd0, who}, {63'd0, e.who});
      check_eq("resp_kind", {62'd0, ack, err}, {62'd0, e.resp});
      if (ack) check_eq("resp_data", {32'd0, dat}, {32'd0, e.data});
      if (e.cyc >= 0) check_eq("resp_cycle", 64'(cyc_n), 64'(e.cyc));
    end
    if (err) last_err_stb = m_stb_o;
    if (who && d_q.size() > 0) begin
      t = d_q.pop_front();
      if (ack && t.we) begin
        check_eq("wr_we", {63'd0, m_we_o}, 64'd1);
        check_eq("wr_sel", {60'd0, m_sel_o}, {60'd0, t.sel});
        check_eq("wr_adr", {32'd0, m_adr_o}, {32'd0, t.adr});
        check_eq("wr_dat", {32'd0, m_dat_o}, {32'd0, t.dat});
      end
    end else if (!who && i_q.size() > 0) begin
      i_q.delete(0);
    end
  endtask

  // Masters and response monitor: act on the falling edge.
  initial begin
    iwb_adr_i = 32'h0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    dwb_adr_i = 32'h0; dwb_dat_i = 32'h0; dwb_we_i = 1'b0;
    dwb_sel_i = 4'h0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (iwb_ack_o || iwb_err_o) resp(1'b0);
        if (dwb_ack_o || dwb_err_o) resp(1'b1);
        if (m_stb_o) stb_seen = 1'b1;
      end
      if (i_q.size() > 0) begin
        iwb_adr_i = i_q[0].adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      end else begin
        iwb_adr_i = 32'h0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      end
      if (d_q.size() > 0) begin
        dwb_adr_i = d_q[0].adr; dwb_dat_i = d_q[0].dat; dwb_we_i = d_q[0].we;
        dwb_sel_i = d_q[0].sel; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      end else begin
        dwb_adr_i = 32'h0; dwb_dat_i = 32'h0; dwb_we_i = 1'b0;
        dwb_sel_i = 4'h0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_slave"}, {25'd0, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o}, 64'd0);
    check_eq({tag, "_wdat"}, {32'd0, m_dat_o}, 64'd0);
    check_eq({tag, "_resp"}, {60'd0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 64'd0);
    check_eq({tag, "_rdat"}, {iwb_dat_o, dwb_dat_o}, 64'd0);
  endtask

  task automatic sync(output int c);
    @(posedge clk);
    #1;
    c = cyc_n;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || i_q.size() != 0 || d_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, {63'd0, (sb.size() == 0 && i_q.size() == 0 && d_q.size() == 0)}, 64'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("in_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("after_release");

    // Tie straight after reset: I, D, I, D.
    sync(k);
    i_q.push_back('{32'h0000_0200, 1'b0, 32'h0, 4'hF});
    i_q.push_back('{32'h0000_0204, 1'b0, 32'h0, 4'hF});
    d_q.push_back('{32'h0000_1000, 1'b1, 32'hCAFE_0001, 4'b0011});
    d_q.push_back('{32'h0000_0300, 1'b0, 32'h0, 4'hF});
    sb.push_back('{1'b0, 2'b10, rdata_fn(32'h0000_0200), -1});
    sb.push_back('{1'b1, 2'b10, rdata_fn(32'h0000_1000), -1});
    sb.push_back('{1'b0, 2'b10, rdata_fn(32'h0000_0204), -1});
    sb.push_back('{1'b1, 2'b10, rdata_fn(32'h0000_0300), -1});
    wait_done("rr_done");

    // Single fetch with exact timing.
    sync(k);
    i_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 4'hF});
    sb.push_back('{1'b0, 2'b10, 32'h0000_0013, k + 2});
    repeat (2) @(negedge clk);
    #1 check_eq("fetch_grant_stb", {31'd0, m_stb_o, m_adr_o}, {31'd0, 1'b1, 32'h0000_0100});
    check_eq("fetch_grant_sel", {59'd0, m_we_o, m_sel_o}, {59'd0, 1'b0, 4'hF});
    repeat (2) @(negedge clk);
    #1 check_eq("fetch_done_stb", {62'd0, m_cyc_o, m_stb_o}, 64'd0);
    wait_done("fetch_done");

    // Out-of-range write: error without touching the slave.
    sync(k);
    stb_seen = 1'b0;
    d_q.push_back('{32'h0000_9000, 1'b1, 32'h1234_5678, 4'hF});
    sb.push_back('{1'b1, 2'b01, 32'h0, k + 1});
    wait_done("oor_done");
    check_eq("oor_no_stb", {63'd0, stb_seen}, 64'd0);

    // Slave ack and err together: err wins.
    sync(k);
    slave_mode = 2;
    d_q.push_back('{32'h0000_0600, 1'b0, 32'h0, 4'hF});
    sb.push_back('{1'b1, 2'b01, 32'h0, k + 2});
    wait_done("ackerr_done");

    // Hung slave: watchdog error.
    sync(k);
    slave_mode = 1;
    i_q.push_back('{32'h0000_0400, 1'b0, 32'h0, 4'hF});
    sb.push_back('{1'b0, 2'b01, 32'h0, k + 9});
    wait_done("timeout_done");
    check_eq("timeout_stb_low", {63'd0, last_err_stb}, 64'd0);

    // Reset while D waits on a hung slave, then a pending tie.
    sync(k);
    d_q.push_back('{32'h0000_0500, 1'b0, 32'h0, 4'hF});
    repeat (3) @(negedge clk);
    #1 check_eq("gd_waiting", {31'd0, m_stb_o, m_adr_o}, {31'd0, 1'b1, 32'h0000_0500});
    #1 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    d_q.delete();
    slave_mode = 0;
    i_q.push_back('{32'h0000_0700, 1'b0, 32'h0, 4'hF});
    d_q.push_back('{32'h0000_0704, 1'b0, 32'h0, 4'hF});
    sb.push_back('{1'b0, 2'b10, rdata_fn(32'h0000_0700), -1});
    sb.push_back('{1'b1, 2'b10, rdata_fn(32'h0000_0704), -1});
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("post_reset");
    wait_done("tie_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
